// File: rtl/matmul_seq_pkg.sv
// matmul_seq_pkg: shared types and helpers for the bit-serial MVM sequencer.
//   state_t   - sequencer states
//   PHASE_*   - phase encodings (positive / negative input half)
//   sat_shl1  - left shift by one that saturates to all-ones of width w
package matmul_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_EXT_ON,
    ST_INF_OFF,
    ST_SPI_TRIG,
    ST_SPI_WAIT,
    ST_INF_ON,
    ST_EXT_OFF,
    ST_CDS_TRIG,
    ST_CDS_WAIT,
    ST_SAMPLE_TRIG,
    ST_SAMPLE_WAIT,
    ST_PHASE_DONE
  } state_t;

  localparam logic PHASE_POS = 1'b0;
  localparam logic PHASE_NEG = 1'b1;

  // Doubling the pulse count must never wrap: once the MSB is set the next
  // doubling would overflow, so the result pins at all-ones.
  function automatic logic [31:0] sat_shl1(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (v[w-1]) return mask;
    return (v << 1) & mask;
  endfunction

endpackage

// File: rtl/matmul_bitserial_seq_if.sv
// matmul_bitserial_seq_if: host/engine-facing signal bundle of the sequencer.
//   slave  modport - the sequencer: takes start/config/idle, drives controls
//   master modport - host regs + SPI/neuron engines: the opposite directions
// Build option MATMUL_SEQ_TIMEOUT_EN adds the timeout_err status signal.
interface matmul_bitserial_seq_if #(
  parameter int NUM_CORES = 4,
  parameter int MAX_BITS  = 8,
  parameter int PULSE_W   = 8
);
  localparam int NB_W = $clog2(MAX_BITS + 1);
  localparam int BI_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  logic                 trigger;
  logic                 abort;
  logic                 signed_mode;
  logic                 cds;
  logic                 reg_reset_en;
  logic [NB_W-1:0]      num_bits;
  logic [PULSE_W-1:0]   pulse_multiplier;
  logic [NUM_CORES-1:0] core_en;
  logic [NUM_CORES-1:0] neuron_idle;
  logic                 spi_idle;

  logic                 idle;
  logic                 done;
  logic [NUM_CORES-1:0] neuron_sample_trigger;
  logic [NUM_CORES-1:0] neuron_cds_trigger;
  logic                 spi_write_trigger;
  logic                 turn_off_inference;
  logic                 ext_inference_enable;
  logic                 phase;
  logic [BI_W-1:0]      bit_index;
  logic [PULSE_W-1:0]   num_pulses;
  logic                 reg_reset;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  logic                 timeout_err;
`endif

  modport slave (
    input  trigger, abort, signed_mode, cds, reg_reset_en, num_bits,
           pulse_multiplier, core_en, neuron_idle, spi_idle,
    output idle, done, neuron_sample_trigger, neuron_cds_trigger,
           spi_write_trigger, turn_off_inference, ext_inference_enable,
           phase, bit_index, num_pulses, reg_reset
`ifdef MATMUL_SEQ_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport master (
    output trigger, abort, signed_mode, cds, reg_reset_en, num_bits,
           pulse_multiplier, core_en, neuron_idle, spi_idle,
    input  idle, done, neuron_sample_trigger, neuron_cds_trigger,
           spi_write_trigger, turn_off_inference, ext_inference_enable,
           phase, bit_index, num_pulses, reg_reset
`ifdef MATMUL_SEQ_TIMEOUT_EN
    , input timeout_err
`endif
  );

endinterface

// File: rtl/matmul_bitserial_seq_trigger_pulse.sv
// seq_trigger_pulse: counts how long a trigger state has been occupied.
//   clk, rst - clock, async active-high reset
//   en       - high while the owning trigger state is occupied
//   fin      - high in the last (TRIG_CYCLES-th) cycle of the trigger
// The count is cleared whenever en is low, so every entry starts from zero.
module seq_trigger_pulse #(
  parameter int TRIG_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic fin
);
  localparam int CW = $clog2(TRIG_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (!en) cnt <= '0;
    else          cnt <= cnt + CW'(1);
  end

  assign fin = en && (cnt == CW'(TRIG_CYCLES - 1));

endmodule

// File: rtl/matmul_bitserial_seq.sv
// matmul_bitserial_seq: bit-serial matrix-vector sequencer.
// Walks the input bits LSB first (one or two phases per bit), and for each
// phase drives SPI input write, then optional CDS and a sample on all enabled
// cores, doubling the pulse count per bit with saturation.
//   clk, rst - clock, async active-high reset
//   bus      - matmul_bitserial_seq_if.slave: start/abort/config, engine
//              idles in; sequencing controls and status out
// Build option MATMUL_SEQ_TIMEOUT_EN: wait states give up after
// TIMEOUT_CYCLES cycles, returning to IDLE with sticky bus.timeout_err.
module matmul_bitserial_seq
  import matmul_seq_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int MAX_BITS    = 8,
  parameter int PULSE_W     = 8,
  parameter int TRIG_CYCLES = 4
`ifdef MATMUL_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  matmul_bitserial_seq_if.slave  bus
);
  localparam int NB_W = $clog2(MAX_BITS + 1);
  localparam int BI_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  state_t state, next_state;

  // run configuration captured at start
  logic                 signed_lat, cds_lat, rr_en_lat;
  logic [NB_W-1:0]      nb_lat;
  logic [NUM_CORES-1:0] core_en_lat;

  logic                 phase_q;
  logic [BI_W-1:0]      bit_index_q;
  logic [PULSE_W-1:0]   num_pulses_q;

  logic                 start, all_idle, first_phase, last_bit, done_set;
  logic [NB_W-1:0]      nb_in;
  logic [2:0]           trig_en, trig_fin;   // [0]=spi [1]=cds [2]=sample

  // registered Moore outputs
  logic                 idle_q, done_q, spi_q, toff_q, ext_q, rr_q;
  logic [NUM_CORES-1:0] smp_q, cdst_q;
  logic                 o_idle, o_spi, o_toff, o_ext, o_rr;
  logic [NUM_CORES-1:0] o_smp, o_cdst;

  assign start       = (state == ST_IDLE) && bus.trigger && !bus.abort;
  assign nb_in       = (bus.num_bits > NB_W'(MAX_BITS)) ? NB_W'(MAX_BITS) : bus.num_bits;
  assign all_idle    = &(bus.neuron_idle | ~core_en_lat);
  assign first_phase = (bit_index_q == '0) && (phase_q == PHASE_POS);
  assign last_bit    = (NB_W'(bit_index_q) == nb_lat - NB_W'(1));

  assign trig_en = {state == ST_SAMPLE_TRIG, state == ST_CDS_TRIG, state == ST_SPI_TRIG};

  for (genvar g = 0; g < 3; g++) begin : g_trig
    seq_trigger_pulse #(.TRIG_CYCLES(TRIG_CYCLES)) u_trig (
      .clk (clk),
      .rst (rst),
      .en  (trig_en[g]),
      .fin (trig_fin[g])
    );
  end

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wt_cnt;
  logic          in_wait, tmo_hit, tmo_set, tmo_err_q;

  assign in_wait = state inside {ST_INF_OFF, ST_SPI_WAIT, ST_EXT_OFF, ST_CDS_WAIT, ST_SAMPLE_WAIT};
  assign tmo_hit = in_wait && (wt_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wt_cnt    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      wt_cnt <= (in_wait && next_state == state) ? wt_cnt + TW'(1) : '0;
      if (start)        tmo_err_q <= 1'b0;
      else if (tmo_set) tmo_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // next state
  always_comb begin
    next_state = state;
    done_set   = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    tmo_set    = 1'b0;
`endif
    unique case (state)
      ST_IDLE:
        if (bus.trigger) begin
          if (bus.num_bits != '0) next_state = ST_EXT_ON;
          else                    done_set   = 1'b1;
        end
      ST_EXT_ON:      next_state = ST_INF_OFF;
      ST_INF_OFF:     if (bus.spi_idle) next_state = ST_SPI_TRIG;
      ST_SPI_TRIG:    if (trig_fin[0])  next_state = ST_SPI_WAIT;
      ST_SPI_WAIT:    if (bus.spi_idle) next_state = ST_INF_ON;
      ST_INF_ON:      next_state = ST_EXT_OFF;
      ST_EXT_OFF:
        if (all_idle) next_state = (cds_lat && first_phase) ? ST_CDS_TRIG : ST_SAMPLE_TRIG;
      ST_CDS_TRIG:    if (trig_fin[1])  next_state = ST_CDS_WAIT;
      ST_CDS_WAIT:    if (all_idle)     next_state = ST_SAMPLE_TRIG;
      ST_SAMPLE_TRIG: if (trig_fin[2])  next_state = ST_SAMPLE_WAIT;
      ST_SAMPLE_WAIT: if (all_idle)     next_state = ST_PHASE_DONE;
      ST_PHASE_DONE:
        if (!(signed_lat && phase_q == PHASE_POS) && last_bit) begin
          next_state = ST_IDLE;
          done_set   = 1'b1;
        end else begin
          next_state = ST_EXT_ON;
        end
      default:        next_state = ST_IDLE;
    endcase
`ifdef MATMUL_SEQ_TIMEOUT_EN
    // a legitimate exit in the same cycle takes precedence over the timeout
    if (tmo_hit && next_state == state) begin
      next_state = ST_IDLE;
      tmo_set    = 1'b1;
    end
`endif
    if (bus.abort) begin
      next_state = ST_IDLE;
      done_set   = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      tmo_set    = 1'b0;
`endif
    end
  end

  // output decode from next_state, registered below so it lines up with state
  always_comb begin
    o_idle = (next_state == ST_IDLE);
    o_ext  = next_state inside {ST_EXT_ON, ST_INF_OFF, ST_SPI_TRIG, ST_SPI_WAIT, ST_INF_ON};
    o_toff = next_state inside {ST_INF_OFF, ST_SPI_TRIG, ST_SPI_WAIT};
    o_spi  = (next_state == ST_SPI_TRIG);
    o_cdst = (next_state == ST_CDS_TRIG)    ? core_en_lat : '0;
    o_smp  = (next_state == ST_SAMPLE_TRIG) ? core_en_lat : '0;
    o_rr   = (next_state == ST_PHASE_DONE)  && rr_en_lat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= 1'b1;
      done_q <= 1'b0;
      ext_q  <= 1'b0;
      toff_q <= 1'b0;
      spi_q  <= 1'b0;
      cdst_q <= '0;
      smp_q  <= '0;
      rr_q   <= 1'b0;
    end else begin
      idle_q <= o_idle;
      done_q <= done_set;
      ext_q  <= o_ext;
      toff_q <= o_toff;
      spi_q  <= o_spi;
      cdst_q <= o_cdst;
      smp_q  <= o_smp;
      rr_q   <= o_rr;
    end
  end

  // config latch and bit/phase/pulse bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_lat   <= 1'b0;
      cds_lat      <= 1'b0;
      rr_en_lat    <= 1'b0;
      nb_lat       <= '0;
      core_en_lat  <= '0;
      phase_q      <= PHASE_POS;
      bit_index_q  <= '0;
      num_pulses_q <= '0;
    end else if (start) begin
      signed_lat   <= bus.signed_mode;
      cds_lat      <= bus.cds;
      rr_en_lat    <= bus.reg_reset_en;
      nb_lat       <= nb_in;
      core_en_lat  <= bus.core_en;
      phase_q      <= PHASE_POS;
      bit_index_q  <= '0;
      num_pulses_q <= bus.pulse_multiplier;
    end else if (state == ST_PHASE_DONE && !bus.abort) begin
      if (signed_lat && phase_q == PHASE_POS) begin
        phase_q <= PHASE_NEG;
      end else begin
        phase_q <= PHASE_POS;
        if (!last_bit) begin
          bit_index_q  <= bit_index_q + BI_W'(1);
          num_pulses_q <= PULSE_W'(sat_shl1(32'(num_pulses_q), PULSE_W));
        end
      end
    end
  end

  assign bus.idle                  = idle_q;
  assign bus.done                  = done_q;
  assign bus.ext_inference_enable  = ext_q;
  assign bus.turn_off_inference    = toff_q;
  assign bus.spi_write_trigger     = spi_q;
  assign bus.neuron_cds_trigger    = cdst_q;
  assign bus.neuron_sample_trigger = smp_q;
  assign bus.reg_reset             = rr_q;
  assign bus.phase                 = phase_q;
  assign bus.bit_index             = bit_index_q;
  assign bus.num_pulses            = num_pulses_q;

endmodule

// File: tb/tb_matmul_bitserial_seq.sv
// tb_matmul_bitserial_seq: directed + randomized bench for the sequencer.
// Simple SPI/neuron engine models acknowledge triggers after ack_lat cycles;
// a monitor logs every trigger; each run is compared against the expected
// phase list derived from the run configuration.
module tb_matmul_bitserial_seq;
  localparam int NC = 4;
  localparam int MB = 8;
  localparam int PW = 8;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_bitserial_seq_if #(.NUM_CORES(NC), .MAX_BITS(MB), .PULSE_W(PW)) bus ();

  matmul_bitserial_seq #(
    .NUM_CORES(NC), .MAX_BITS(MB), .PULSE_W(PW), .TRIG_CYCLES(TC)
`ifdef MATMUL_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // engine model controls (written only by the main initial block)
  logic [NC-1:0] stuck     = '0;
  bit            spi_stuck = 1'b0;
  int            ack_lat   = 10;

  // engine models: busy while triggered and for ack_lat cycles after
  int nbusy [NC];
  int sbusy = 0;
  always @(negedge clk) begin
    logic [NC-1:0] ni;
    for (int c = 0; c < NC; c++) begin
      if (bus.neuron_sample_trigger[c] || bus.neuron_cds_trigger[c]) nbusy[c] = ack_lat;
      else if (nbusy[c] > 0) nbusy[c] = nbusy[c] - 1;
      ni[c] = (nbusy[c] == 0) && !stuck[c];
    end
    bus.neuron_idle = ni;
    if (bus.spi_write_trigger) sbusy = ack_lat;
    else if (sbusy > 0) sbusy = sbusy - 1;
    bus.spi_idle = (sbusy == 0) && !spi_stuck;
  end

  // monitor: log trigger rising edges and pulse widths
  int spi_ph[$], spi_bi[$], spi_np[$];
  int smp_ph[$], smp_bi[$], smp_mk[$];
  int cds_pos[$];
  int cds_cnt = 0, rr_cnt = 0, done_cnt = 0, width_err = 0;
  int spi_len = 0, smp_len = 0, cds_len = 0;
  always @(negedge clk) begin
    if (bus.spi_write_trigger) begin
      if (spi_len == 0) begin
        spi_ph.push_back(int'(bus.phase));
        spi_bi.push_back(int'(bus.bit_index));
        spi_np.push_back(int'(bus.num_pulses));
      end
      spi_len++;
    end else if (spi_len != 0) begin
      if (spi_len != TC) width_err++;
      spi_len = 0;
    end
    if (bus.neuron_sample_trigger != '0) begin
      if (smp_len == 0) begin
        smp_ph.push_back(int'(bus.phase));
        smp_bi.push_back(int'(bus.bit_index));
        smp_mk.push_back(int'(bus.neuron_sample_trigger));
      end
      smp_len++;
    end else if (smp_len != 0) begin
      if (smp_len != TC) width_err++;
      smp_len = 0;
    end
    if (bus.neuron_cds_trigger != '0) begin
      if (cds_len == 0) begin
        cds_cnt++;
        cds_pos.push_back(smp_ph.size());
      end
      cds_len++;
    end else if (cds_len != 0) begin
      if (cds_len != TC) width_err++;
      cds_len = 0;
    end
    if (bus.reg_reset) rr_cnt++;
    if (bus.done) done_cnt++;
  end

  int b_spi, b_smp, b_cds, b_rr, b_done, b_werr;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input bit sgn, input bit c, input bit rr, input int nb,
                           input int mult, input logic [NC-1:0] ce);
    b_spi = spi_ph.size(); b_smp = smp_ph.size(); b_cds = cds_cnt;
    b_rr = rr_cnt; b_done = done_cnt; b_werr = width_err;
    @(negedge clk);
    bus.signed_mode      = sgn;
    bus.cds              = c;
    bus.reg_reset_en     = rr;
    bus.num_bits         = 4'(nb);
    bus.pulse_multiplier = 8'(mult);
    bus.core_en          = ce;
    bus.trigger          = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    // config changes mid-run must be ignored
    bus.signed_mode      = 1'($urandom);
    bus.cds              = 1'($urandom);
    bus.reg_reset_en     = 1'($urandom);
    bus.num_bits         = 4'($urandom);
    bus.pulse_multiplier = 8'($urandom);
    bus.core_en          = 4'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == b_done && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, int'(done_cnt != b_done), 1);
  endtask

  // reference: expected phase list from the configuration alone
  task automatic check_run(input string tag, input bit sgn, input bit c, input bit rr,
                           input int nb, input int mult, input logic [NC-1:0] ce);
    int nbe, nph, nsmp, i, np;
    nbe  = (nb > MB) ? MB : nb;
    nph  = nbe * (sgn ? 2 : 1);
    nsmp = (ce != '0) ? nph : 0;
    chk({tag, "_spi_cnt"}, spi_ph.size() - b_spi, nph);
    chk({tag, "_smp_cnt"}, smp_ph.size() - b_smp, nsmp);
    i = 0;
    for (int b = 0; b < nbe; b++) begin
      np = mult * (1 << b);
      if (np > 255) np = 255;
      for (int p = 0; p < (sgn ? 2 : 1); p++) begin
        if (b_spi + i < spi_ph.size()) begin
          chk({tag, "_spi_phase"},  spi_ph[b_spi + i], p);
          chk({tag, "_spi_bit"},    spi_bi[b_spi + i], b);
          chk({tag, "_spi_pulses"}, spi_np[b_spi + i], np);
        end
        if (nsmp != 0 && b_smp + i < smp_ph.size()) begin
          chk({tag, "_smp_phase"}, smp_ph[b_smp + i], p);
          chk({tag, "_smp_bit"},   smp_bi[b_smp + i], b);
          chk({tag, "_smp_mask"},  smp_mk[b_smp + i], int'(ce));
        end
        i++;
      end
    end
    chk({tag, "_cds_cnt"}, cds_cnt - b_cds, int'(c && nph > 0 && ce != '0));
    if (cds_cnt != b_cds) chk({tag, "_cds_first"}, cds_pos[cds_pos.size() - 1], b_smp);
    chk({tag, "_rr_cnt"}, rr_cnt - b_rr, rr ? nph : 0);
    chk({tag, "_done_cnt"}, done_cnt - b_done, 1);
    chk({tag, "_width"}, width_err - b_werr, 0);
    chk({tag, "_idle_end"}, int'(bus.idle), 1);
  endtask

  task automatic full_run(input string tag, input bit sgn, input bit c, input bit rr,
                          input int nb, input int mult, input logic [NC-1:0] ce);
    start_run(sgn, c, rr, nb, mult, ce);
    wait_done(tag);
    repeat (2) @(posedge clk);
    check_run(tag, sgn, c, rr, nb, mult, ce);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.trigger = 1'b0; bus.abort = 1'b0; bus.signed_mode = 1'b0; bus.cds = 1'b0;
    bus.reg_reset_en = 1'b0; bus.num_bits = '0; bus.pulse_multiplier = '0; bus.core_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_idle",  int'(bus.idle), 1);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_ext",   int'(bus.ext_inference_enable), 0);
    chk("rst_toff",  int'(bus.turn_off_inference), 0);
    chk("rst_spi",   int'(bus.spi_write_trigger), 0);
    chk("rst_smp",   int'(bus.neuron_sample_trigger), 0);
    chk("rst_cds",   int'(bus.neuron_cds_trigger), 0);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_bit",   int'(bus.bit_index), 0);
    chk("rst_np",    int'(bus.num_pulses), 0);
    chk("rst_rr",    int'(bus.reg_reset), 0);
`ifdef MATMUL_SEQ_TIMEOUT_EN
    chk("rst_tmo",   int'(bus.timeout_err), 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    full_run("unsigned", 1'b0, 1'b0, 1'b1, 3, 5, 4'b1111);
    full_run("signed",   1'b1, 1'b1, 1'b1, 2, 5, 4'b1111);
    full_run("sat",      1'b0, 1'b0, 1'b0, 3, 8'hC0, 4'b1111);
    stuck = 4'b1010;
    full_run("partial",  1'b0, 1'b1, 1'b0, 3, 3, 4'b0101);
    stuck = '0;
    full_run("nocores",  1'b1, 1'b1, 1'b0, 2, 7, 4'b0000);
    full_run("zero_bits", 1'b1, 1'b1, 1'b1, 0, 9, 4'b1111);
    full_run("clamp",    1'b0, 1'b0, 1'b1, 12, 1, 4'b0011);

    // abort while waiting for the sample acknowledge
    start_run(1'b0, 1'b0, 1'b1, 3, 5, 4'b1111);
    n = 0;
    while (smp_ph.size() == b_smp && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reach_sample", smp_ph.size() - b_smp, 1);
    repeat (TC + 2) @(negedge clk);
    chk("abort_pre_trig", int'(bus.neuron_sample_trigger), 0);
    chk("abort_pre_idle", int'(bus.idle), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_idle", int'(bus.idle), 1);
    chk("abort_ext",  int'(bus.ext_inference_enable), 0);
    repeat (20) @(posedge clk);
    chk("abort_no_done", done_cnt - b_done, 0);
    chk("abort_idle_hold", int'(bus.idle), 1);

    // trigger and abort together: abort wins
    b_done = done_cnt;
    @(negedge clk);
    bus.num_bits = 4'd2; bus.trigger = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0; bus.abort = 1'b0;
    chk("trig_abort_idle", int'(bus.idle), 1);
    chk("trig_abort_ext",  int'(bus.ext_inference_enable), 0);
    repeat (5) @(posedge clk);
    chk("trig_abort_no_done", done_cnt - b_done, 0);

    full_run("restart", 1'b0, 1'b0, 1'b0, 2, 9, 4'b1111);

    // randomized configurations
    for (int r = 0; r < 6; r++) begin
      bit rs, rc, rrr;
      int rnb, rm;
      logic [NC-1:0] rce;
      rs  = 1'($urandom);
      rc  = 1'($urandom);
      rrr = 1'($urandom);
      rnb = int'($urandom_range(0, 10));
      rm  = int'($urandom_range(0, 255));
      rce = 4'($urandom);
      ack_lat = int'($urandom_range(1, 12));
      full_run($sformatf("rand%0d", r), rs, rc, rrr, rnb, rm, rce);
    end
    ack_lat = 10;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    spi_stuck = 1'b1;
    start_run(1'b0, 1'b0, 1'b0, 2, 4, 4'b1111);
    n = 0;
    begin
      int toff = 0;
      while (!bus.idle && n < 1000) begin
        if (bus.turn_off_inference) toff++;
        @(negedge clk);
        n++;
      end
      chk("tmo_cycles", toff, 100);
    end
    chk("tmo_idle", int'(bus.idle), 1);
    chk("tmo_err",  int'(bus.timeout_err), 1);
    repeat (3) @(posedge clk);
    chk("tmo_no_done", done_cnt - b_done, 0);
    spi_stuck = 1'b0;
    repeat (2) @(negedge clk);
    start_run(1'b0, 1'b0, 1'b0, 1, 4, 4'b1111);
    chk("tmo_err_clear", int'(bus.timeout_err), 0);
    wait_done("tmo_after");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_bitserial_seq.md
Name: matmul_bitserial_seq

Overview:
- Parametrised bit-serial MVM sequencer for multi-core inference.
- Issues per-bit, per-phase control sequences to the SPI input-write engine and the neuron sample/CDS engines of up to NUM_CORES cores.
- Supports unsigned and signed (positive/negative phase) inputs, a per-core enable mask, abort, and a pulse count that doubles per bit with saturation.
- Sits between the host register bank and the per-core neuron and SPI controllers.

Parameters:
- NUM_CORES, 4: number of cores whose neuron controllers are sequenced.
- MAX_BITS, 8: maximum input bit count; sets the width of num_bits and bit_index.
- PULSE_W, 8: width of num_pulses.
- TRIG_CYCLES, 4: cycles each trigger output is held high (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- trigger  in  1  start; sampled in IDLE only
- abort  in  1  synchronous abort, any state
- signed_mode  in  1  1 = two phases per bit (pos, neg); 0 = one phase
- cds  in  1  issue CDS before the first sample of the run
- reg_reset_en  in  1  pulse reg_reset at every phase end
- num_bits  in  $clog2(MAX_BITS+1)  bits per run
- pulse_multiplier  in  PULSE_W  pulses for bit 0
- core_en  in  NUM_CORES  cores participating
- neuron_idle  in  NUM_CORES  per-core neuron controller idle
- spi_idle  in  1  SPI write engine idle
- idle  out  1  sequencer in IDLE
- done  out  1  one-cycle pulse on normal completion
- neuron_sample_trigger  out  NUM_CORES  masked by core_en
- neuron_cds_trigger  out  NUM_CORES  masked by core_en
- spi_write_trigger  out  1
- turn_off_inference  out  1
- ext_inference_enable  out  1
- phase  out  1  0 = positive, 1 = negative
- bit_index  out  $clog2(MAX_BITS)  current bit, LSB first
- num_pulses  out  PULSE_W  pulses for current bit
- reg_reset  out  1

Behaviour:
- Reset: idle=1; all other outputs 0; state=IDLE; all counters 0.
- Moore outputs, registered from next_state, so each output is valid in the same cycle its state is occupied.
- On trigger, latch signed_mode, cds, reg_reset_en, num_bits, pulse_multiplier and core_en; later input changes are ignored until IDLE.
- all_idle = &(neuron_idle | ~core_en_latched).
- States and transitions:
  - IDLE: trigger & num_bits≠0 → EXT_ON; trigger & num_bits==0 → IDLE with a done pulse.
  - EXT_ON (ext_inference_enable=1): → INF_OFF.
  - INF_OFF (ext=1, turn_off_inference=1): spi_idle → SPI_TRIG.
  - SPI_TRIG (spi_write_trigger=1, ext=1, toff=1): held exactly TRIG_CYCLES cycles → SPI_WAIT.
  - SPI_WAIT (ext=1, toff=1): spi_idle → INF_ON.
  - INF_ON (ext=1): → EXT_OFF.
  - EXT_OFF: all_idle → CDS_TRIG if cds latched and first phase of the run; otherwise → SAMPLE_TRIG.
  - CDS_TRIG (cds trigger=core_en): held TRIG_CYCLES → CDS_WAIT; all_idle → SAMPLE_TRIG.
  - SAMPLE_TRIG (sample trigger=core_en): held TRIG_CYCLES → SAMPLE_WAIT; all_idle → PHASE_DONE.
  - PHASE_DONE (reg_reset=reg_reset_en): 1 cycle.
    - If signed_mode and phase==0: phase←1, → EXT_ON.
    - Else: phase←0.
      - If bit_index==num_bits-1 → IDLE, done=1 for one cycle.
      - Otherwise bit_index+1, num_pulses doubled, → EXT_ON.
- num_pulses: loaded with pulse_multiplier on trigger; shifted left once per completed bit; saturates at all-ones on overflow (no wrap).
- num_bits > MAX_BITS is clamped to MAX_BITS.
- core_en==0: all_idle is 1 and triggers stay 0; the sequence still runs against SPI.
- abort: highest priority, any non-IDLE state → IDLE next cycle; triggers drop; no done pulse. trigger with abort in the same cycle: abort wins.
- Wait states hold indefinitely absent the optional feature.

Optional Feature:
- Macro: MATMUL_SEQ_TIMEOUT_EN.
- With macro:
  - Parameter TIMEOUT_CYCLES (default 65535).
  - Extra output timeout_err (1 bit, reset 0).
  - A wait-state counter runs in INF_OFF, SPI_WAIT, EXT_OFF, CDS_WAIT and SAMPLE_WAIT, and clears on each state change.
  - On reaching TIMEOUT_CYCLES: → IDLE, timeout_err=1 (sticky until next trigger), no done pulse.
- Without macro: no counter; no timeout_err port.

Decomposition:
- Shared package matmul_seq_pkg: state enum, phase constants (PHASE_POS/PHASE_NEG), saturating-shift function.
- One sub-module, seq_trigger_pulse: counts TRIG_CYCLES and flags completion. It is reused for SPI, CDS and sample triggers.

Test Plan:
- Unsigned, num_bits=3, multiplier=5, cds=0, core_en=4'b1111, idles ack after 10 cycles → 3 SPI and 3 sample triggers; num_pulses 5,10,20; each trigger 4 cycles wide; single done.
- Signed, num_bits=2, cds=1 → phases pos,neg,pos,neg; exactly one CDS, before the first sample; bit_index 0,0,1,1; num_pulses 5,5,10,10.
- multiplier=8'hC0, num_bits=3 → num_pulses C0, FF, FF (saturated).
- core_en=4'b0101; neuron_idle[1] stuck 0, neuron_idle[3] stuck 0 → run completes; sample triggers only on bits 0,2.
- Abort asserted during SAMPLE_WAIT → IDLE next cycle; no done; a following trigger restarts at bit 0 with pulse_multiplier.
- Macro on, TIMEOUT_CYCLES=100, spi_idle held 0 → timeout_err=1 after 100 cycles in INF_OFF; idle=1; no done.
